// File: rtl/pll_loader_pkg.sv
// Shared definitions for the PLL register loader: the sequencer state
// encoding, the default parameter values and a small sizing helper.
package pll_loader_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      SHIFT = 3'd2,
      LATCH = 3'd3,
      GAP   = 3'd4,
      FIN   = 3'd5
   } state_e;

   localparam int DEF_REG_W    = 32;
   localparam int DEF_NUM_REGS = 6;
   localparam int DEF_CLK_DIV  = 3;
   localparam int DEF_LE_W     = 4;
   localparam int DEF_GAP_W    = 8;
   localparam int DEF_LOCK_CNT = 64;

   // Largest of the three phase lengths sets the width of the shared phase counter.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return m;
   endfunction

endpackage

// File: rtl/pll_lock_mon.sv
// Lock-detect monitor: brings the asynchronous ld pin into the clk domain and
// reports lock only after LOCK_CNT consecutive high cycles.
module pll_lock_mon
   import pll_loader_pkg::*;
#(
   parameter int LOCK_CNT = DEF_LOCK_CNT
) (
   input  logic clk,
   input  logic rst,
   input  logic ld,
   input  logic hold,
   output logic locked
);

   localparam int CW = $clog2(LOCK_CNT + 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic          locked_q, locked_d;

   // The counter saturates at LOCK_CNT; a low ld or an active load restarts it.
   always_comb begin
      sync1_d = ld;
      sync2_d = sync1_q;
      cnt_d   = cnt_q;
      if (hold || !sync2_q) begin
         cnt_d = '0;
      end else if (cnt_q != CW'(LOCK_CNT)) begin
         cnt_d = cnt_q + CW'(1);
      end
      locked_d = (cnt_d == CW'(LOCK_CNT));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         cnt_q    <= '0;
         locked_q <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         cnt_q    <= cnt_d;
         locked_q <= locked_d;
      end
   end

   assign locked = locked_q;

endmodule

// File: rtl/pll_reg_loader.sv
// Serial register loader for a PLL synthesizer: shifts the selected words out
// MSB first, highest index first, latching each one with an le pulse.
module pll_reg_loader
   import pll_loader_pkg::*;
#(
   parameter int REG_W    = DEF_REG_W,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int CLK_DIV  = DEF_CLK_DIV,
   parameter int LE_W     = DEF_LE_W,
   parameter int GAP_W    = DEF_GAP_W,
   parameter int LOCK_CNT = DEF_LOCK_CNT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [NUM_REGS*REG_W-1:0] reg_data,
   input  logic [NUM_REGS-1:0]       reg_mask,
   output logic                      busy,
   output logic                      done,
   output logic                      sclk,
   output logic                      sdata,
   output logic                      le,
   output logic                      ce,
   input  logic                      ld,
   output logic                      locked
);

   localparam int CNT_W = $clog2(max3(CLK_DIV, LE_W, GAP_W) + 1);
   localparam int BIT_W = (REG_W > 1) ? $clog2(REG_W) : 1;
   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   state_e                    state_q, state_d;
   logic [NUM_REGS*REG_W-1:0] data_q,  data_d;
   logic [NUM_REGS-1:0]       mask_q,  mask_d;
   logic [IDX_W-1:0]          idx_q,   idx_d;
   logic [REG_W-1:0]          sr_q,    sr_d;
   logic [CNT_W-1:0]          cnt_q,   cnt_d;
   logic [BIT_W-1:0]          bit_q,   bit_d;
   logic                      busy_q,  busy_d;
   logic                      done_q,  done_d;
   logic                      sclk_q,  sclk_d;
   logic                      sdata_q, sdata_d;
   logic                      le_q,    le_d;
   logic                      ce_q,    ce_d;

   int                        sel_i;
   logic                      sel_found;

   // Next-state and next-output logic; every output is registered with the state.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      mask_d  = mask_q;
      idx_d   = idx_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      sclk_d  = 1'b0;
      sdata_d = 1'b0;
      le_d    = 1'b0;
      ce_d    = 1'b1;

      sel_i     = 0;
      sel_found = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (mask_q[i]) begin
            sel_i     = i;
            sel_found = 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               data_d  = reg_data;
               mask_d  = reg_mask;
               busy_d  = 1'b1;
               state_d = LOAD;
            end
         end
         LOAD: begin
            cnt_d = '0;
            bit_d = '0;
            if (sel_found) begin
               idx_d   = IDX_W'(sel_i);
               sr_d    = data_q[sel_i*REG_W +: REG_W];
               sdata_d = sr_d[REG_W-1];
               state_d = SHIFT;
            end else begin
               done_d  = 1'b1;
               state_d = FIN;
            end
         end
         SHIFT: begin
            sclk_d  = sclk_q;
            sdata_d = sdata_q;
            if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
               cnt_d = '0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else if (bit_q == BIT_W'(REG_W - 1)) begin
                  sclk_d  = 1'b0;
                  sdata_d = 1'b0;
                  le_d    = 1'b1;
                  state_d = LATCH;
               end else begin
                  // Next bit is presented only as sclk falls, so it is stable while high.
                  bit_d   = bit_q + BIT_W'(1);
                  sr_d    = sr_q << 1;
                  sdata_d = sr_d[REG_W-1];
                  sclk_d  = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         LATCH: begin
            le_d = 1'b1;
            if (cnt_q == CNT_W'(LE_W - 1)) begin
               le_d    = 1'b0;
               cnt_d   = '0;
               state_d = GAP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         GAP: begin
            if (cnt_q == CNT_W'(GAP_W - 1)) begin
               mask_d[idx_q] = 1'b0;
               cnt_d         = '0;
               state_d       = LOAD;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         FIN: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         mask_q  <= '0;
         idx_q   <= '0;
         sr_q    <= '0;
         cnt_q   <= '0;
         bit_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sclk_q  <= 1'b0;
         sdata_q <= 1'b0;
         le_q    <= 1'b0;
         ce_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         mask_q  <= mask_d;
         idx_q   <= idx_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         sclk_q  <= sclk_d;
         sdata_q <= sdata_d;
         le_q    <= le_d;
         ce_q    <= ce_d;
      end
   end

   // Holding on busy_d drops lock in the same edge that accepts a start.
   pll_lock_mon #(
      .LOCK_CNT (LOCK_CNT)
   ) u_lock_mon (
      .clk    (clk),
      .rst    (rst),
      .ld     (ld),
      .hold   (busy_d),
      .locked (locked)
   );

   assign busy  = busy_q;
   assign done  = done_q;
   assign sclk  = sclk_q;
   assign sdata = sdata_q;
   assign le    = le_q;
   assign ce    = ce_q;

endmodule

// File: tb/tb_pll_reg_loader.sv
// Self-checking bench for pll_reg_loader: table of mask patterns plus directed
// sequences for ignored starts, mid-word reset and lock debounce.
module tb_pll_reg_loader;

   localparam int REG_W    = 32;
   localparam int NUM_REGS = 6;
   localparam int CLK_DIV  = 2;
   localparam int LE_W     = 4;
   localparam int GAP_W    = 8;
   localparam int LOCK_CNT = 16;

   logic                      clk = 1'b0;
   logic                      rst = 1'b1;
   logic                      start = 1'b0;
   logic                      ld = 1'b0;
   logic [NUM_REGS*REG_W-1:0] reg_data = '0;
   logic [NUM_REGS-1:0]       reg_mask = '0;
   logic busy, done, sclk, sdata, le, ce, locked;

   always #5 clk = ~clk;

   pll_reg_loader #(
      .REG_W    (REG_W),
      .NUM_REGS (NUM_REGS),
      .CLK_DIV  (CLK_DIV),
      .LE_W     (LE_W),
      .GAP_W    (GAP_W),
      .LOCK_CNT (LOCK_CNT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .reg_data (reg_data),
      .reg_mask (reg_mask),
      .busy     (busy),
      .done     (done),
      .sclk     (sclk),
      .sdata    (sdata),
      .le       (le),
      .ce       (ce),
      .ld       (ld),
      .locked   (locked)
   );

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [NUM_REGS-1:0] mask;
      int                  doneCyc;
      int                  nWords;
   } vec_t;

   logic [REG_W-1:0]          words [NUM_REGS];
   logic [NUM_REGS*REG_W-1:0] fullData;

   // Serial-side monitor: rebuilds words on sclk rising edges and measures le pulses.
   logic [REG_W-1:0] capWords [$];
   logic [REG_W-1:0] monSr = '0;
   int   monBits = 0, monLeLen = 0;
   int   lePulses = 0, leBad = 0, sdataViol = 0, sclkRises = 0;
   logic sclkPrev = 1'b0, sdataPrev = 1'b0, lePrev = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         if (!ce) begin
            monBits  = 0;
            monLeLen = 0;
         end else begin
            if (sclk && !sclkPrev) begin
               sclkRises++;
               monSr = {monSr[REG_W-2:0], sdata};
               monBits++;
               if (monBits == REG_W) begin
                  capWords.push_back(monSr);
                  monBits = 0;
               end
            end
            if (sclk && sclkPrev && (sdata != sdataPrev)) sdataViol++;
            if (le) monLeLen++;
            if (!le && lePrev) begin
               lePulses++;
               if (monLeLen != LE_W) leBad++;
               monLeLen = 0;
            end
         end
         sclkPrev  = sclk;
         sdataPrev = sdata;
         lePrev    = le;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Starts a sequence, scrambles the inputs once captured, and waits (bounded) for done.
   task automatic applyStimulus(input logic [NUM_REGS-1:0] mask, input logic [NUM_REGS*REG_W-1:0] data,
                                input bit extraStarts, output int doneCyc, output int busyCyc);
      int cyc;
      reg_mask = mask;
      reg_data = data;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      reg_mask = ~mask;
      reg_data = ~data;
      cyc      = 1;
      doneCyc  = -1;
      busyCyc  = 0;
      while (cyc <= 2000 && doneCyc < 0) begin
         if (busy) busyCyc++;
         if (done) doneCyc = cyc;
         start = extraStarts && (cyc == 10 || cyc == 50);
         if (doneCyc < 0) begin
            @(negedge clk);
            cyc++;
         end
      end
      start = 1'b0;
   endtask

   task automatic checkWords(input string tag, input logic [NUM_REGS-1:0] mask, input int base);
      logic [REG_W-1:0] expQ [$];
      for (int k = NUM_REGS - 1; k >= 0; k--) if (mask[k]) expQ.push_back(words[k]);
      checkOutput($sformatf("%s_word_count", tag), 32'(capWords.size() - base), 32'(expQ.size()));
      for (int k = 0; k < expQ.size(); k++) begin
         if (base + k < capWords.size())
            checkOutput($sformatf("%s_word%0d", tag, k), capWords[base + k], expQ[k]);
      end
   endtask

   vec_t vecs [5];

   initial begin
      int dc, bc, n0, lp0, sr0, cyc, seen;

      words[5] = 32'h00580005;
      words[4] = 32'h008C80FC;
      words[3] = 32'h000004B3;
      words[2] = 32'h00004E42;
      words[1] = 32'h08008011;
      words[0] = 32'h00300000;
      for (int k = 0; k < NUM_REGS; k++) fullData[k*REG_W +: REG_W] = words[k];

      vecs[0] = '{mask: 6'b111111, doneCyc: 848, nWords: 6};
      vecs[1] = '{mask: 6'b000101, doneCyc: 284, nWords: 2};
      vecs[2] = '{mask: 6'b000000, doneCyc: 2,   nWords: 0};
      vecs[3] = '{mask: 6'b100000, doneCyc: 143, nWords: 1};
      vecs[4] = '{mask: 6'b010010, doneCyc: 284, nWords: 2};

      repeat (3) @(negedge clk);
      checkOutput("reset_outputs", {25'b0, busy, done, sclk, sdata, le, ce, locked}, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("ce_after_reset", 32'(ce), 32'h1);
      checkOutput("idle_busy", 32'(busy), 32'h0);

      for (int i = 0; i < 5; i++) begin
         n0  = capWords.size();
         lp0 = lePulses;
         sr0 = sclkRises;
         applyStimulus(vecs[i].mask, fullData, 1'b0, dc, bc);
         @(negedge clk);
         checkOutput($sformatf("v%0d_busy_after", i), 32'(busy), 32'h0);
         checkOutput($sformatf("v%0d_done_after", i), 32'(done), 32'h0);
         repeat (3) @(negedge clk);
         checkOutput($sformatf("v%0d_done_cycle", i), 32'(dc), 32'(vecs[i].doneCyc));
         checkOutput($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'(vecs[i].doneCyc));
         checkOutput($sformatf("v%0d_le_pulses", i), 32'(lePulses - lp0), 32'(vecs[i].nWords));
         checkOutput($sformatf("v%0d_sclk_rises", i), 32'(sclkRises - sr0), 32'(vecs[i].nWords * REG_W));
         checkWords($sformatf("v%0d", i), vecs[i].mask, n0);
      end
      checkOutput("le_width_errors", 32'(leBad), 32'h0);
      checkOutput("sdata_stability", 32'(sdataViol), 32'h0);

      // Extra starts mid-sequence must not restart it or change the captured data.
      n0 = capWords.size();
      applyStimulus(6'b111111, fullData, 1'b1, dc, bc);
      checkOutput("xstart_done_cycle", 32'(dc), 32'd848);
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (busy) seen++;
      end
      checkOutput("xstart_no_rerun", 32'(seen), 32'h0);
      checkWords("xstart", 6'b111111, n0);

      // Reset in bit 17 of R4 abandons the word without an le pulse.
      n0  = capWords.size();
      lp0 = lePulses;
      reg_mask = 6'b111111;
      reg_data = fullData;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
      while (cyc < 212) begin
         @(negedge clk);
         cyc++;
      end
      rst = 1'b1;
      @(negedge clk);
      checkOutput("rst_mid_outputs", {25'b0, busy, done, sclk, sdata, le, ce, locked}, 32'h0);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      checkOutput("rst_mid_le_pulses", 32'(lePulses - lp0), 32'h1);
      checkOutput("rst_mid_words", 32'(capWords.size() - n0), 32'h1);
      if (capWords.size() > n0) checkOutput("rst_mid_first", capWords[n0], words[5]);
      checkOutput("rst_mid_busy", 32'(busy), 32'h0);
      n0 = capWords.size();
      applyStimulus(6'b111111, fullData, 1'b0, dc, bc);
      repeat (3) @(negedge clk);
      checkOutput("rst_resend_done", 32'(dc), 32'd848);
      checkWords("rst_resend", 6'b111111, n0);

      // Lock debounce: a 15-cycle ld burst must not lock.
      seen = 0;
      ld = 1'b1;
      repeat (15) @(negedge clk);
      ld = 1'b0;
      repeat (8) begin
         if (locked) seen++;
         @(negedge clk);
      end
      checkOutput("lock_short_burst", 32'(seen), 32'h0);
      ld = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 17) checkOutput("lock_edge17", 32'(locked), 32'h0);
         if (k == 18) checkOutput("lock_edge18", 32'(locked), 32'h1);
      end
      reg_mask = '0;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("lock_drop_on_start", 32'(locked), 32'h0);
      checkOutput("lock_busy_on_start", 32'(busy), 32'h1);
      repeat (25) @(negedge clk);
      checkOutput("lock_relock", 32'(locked), 32'h1);
      ld = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("lock_lost", 32'(locked), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/pll_reg_loader.md
PLL_REG_LOADER -- requirements
Module: pll_reg_loader

Interface
REQ-001 Parameter REG_W, default 32, serial word width in bits.
REQ-002 Parameter NUM_REGS, default 6, number of registers per load sequence.
REQ-003 Parameter CLK_DIV, default 3, clk cycles per sclk half-period (min 1).
REQ-004 Parameter LE_W, default 4, clk cycles le is held high per word.
REQ-005 Parameter GAP_W, default 8, idle clk cycles after le falls, before the next word.
REQ-006 Parameter LOCK_CNT, default 64, consecutive clk cycles of ld high required for lock.
REQ-007 Clock and reset: one clock, port clk; reset port rst, synchronous and active-high.
REQ-008 Ports, listed as name, direction, width, meaning:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, begin a load sequence.
- reg_data, in, NUM_REGS*REG_W, register words; word i occupies bits [i*REG_W +: REG_W].
- reg_mask, in, NUM_REGS, bit i set means send word i.
- busy, out, 1, sequence in progress.
- done, out, 1, one-cycle pulse at sequence end.
- sclk, out, 1, serial clock.
- sdata, out, 1, serial data.
- le, out, 1, latch enable.
- ce, out, 1, chip enable.
- ld, in, 1, asynchronous lock-detect from the device.
- locked, out, 1, debounced lock status.

Function
REQ-009 States: IDLE, LOAD, SHIFT, LATCH, GAP, FIN.
REQ-010 IDLE, start=1: capture reg_data and reg_mask into internal registers; busy=1 from the next cycle; go to LOAD.
REQ-011 start while busy=1 is ignored, and the captured data is unchanged.
REQ-012 LOAD selects the highest pending index (NUM_REGS-1 down to 0) whose captured mask bit is set, and loads that word into the shift register:
- If a word is selected, go to SHIFT.
- If no bit is pending, go to FIN.
- LOAD lasts exactly 1 cycle.
REQ-013 SHIFT sends the word MSB first over REG_W sclk periods:
- Each period: sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
- sdata changes only at the start of the low half and is stable while sclk is high.
- sclk ends low.
REQ-014 LATCH holds le=1 for LE_W cycles, with sclk=0 and sdata=0.
REQ-015 GAP holds le=0 for GAP_W cycles. It then clears the sent mask bit and returns to LOAD.
REQ-016 FIN pulses done=1 for exactly one cycle, drops busy in the same cycle, and goes to IDLE.
REQ-017 Per-word time is 1 + 2*CLK_DIV*REG_W + LE_W + GAP_W cycles. An all-zero mask gives done 2 cycles after start (LOAD, then FIN).
REQ-018 Outside SHIFT and LATCH: sclk=0, sdata=0, le=0.
REQ-019 ce is 0 in reset and 1 from the first cycle after rst deasserts.
REQ-020 ld passes through a 2-flop synchronizer. A counter counts consecutive cycles with synchronized ld=1:
- locked=1 when the counter reaches LOCK_CNT; the counter saturates there.
- Any synchronized ld=0 clears the counter and locked in the next cycle.
REQ-021 locked is forced to 0 while busy=1, and the lock counter restarts when busy falls.

Reset
REQ-022 rst=1 takes effect at the next clk edge from any state, including mid-word:
- state returns to IDLE.
- busy, done, sclk, sdata, le, ce and locked are all 0.
- The shift register, mask and counters are cleared.
- A partial word is abandoned, and le is never pulsed for it.

Structure
REQ-023 Package pll_loader_pkg holds the state enum and the default parameter constants.
REQ-024 The ld synchronizer and debounce form sub-module pll_lock_mon (ports clk, rst, ld, hold, locked).

Verification
REQ-025 Test parameters: CLK_DIV=2, REG_W=32, NUM_REGS=6, LE_W=4, GAP_W=8, LOCK_CNT=16.
- Stimulus: start with mask 6'b111111, words 0x00580005, 0x008C80FC, 0x000004B3, 0x00004E42, 0x08008011, 0x00300000.
- Required: six words captured on sclk rising edges, in order R5..R0, bit-exact; 6 le pulses of 4 cycles; done at 6*141+2 cycles after start.
REQ-026 mask 6'b000101 → only words 2 and 0 are sent, in that order; done at cycle 284 after start.
REQ-027 mask 0 → no sclk or le activity; done 2 cycles after start; busy high for 2 cycles.
REQ-028 start pulses at cycles 10 and 50 of a sequence → exactly one sequence runs, and the data captured at the first start is sent.
REQ-029 rst=1 during bit 17 of word 4 → all outputs 0 the next cycle and no le pulse; a fresh start then resends from R5.
REQ-030 ld high for 15 cycles then low → locked stays 0. ld high for 20 cycles → locked=1 after 16 cycles plus 2 synchronizer cycles. locked drops when start is accepted.
